mario_sample_player: RTL and testbench
======================================

Name: mario_sample_player

Overview:
- Single-channel PCM sample playback engine for the discrete/analogue sound effects (walk, jump, skid, etc.).
- On a trigger it reads 8-bit unsigned samples from sample ROM through a req/ack handshake and paces them at a fixed output rate.
- Produces one signed 16-bit stream.
- Four instances drive the four inputs of the sound mixer stage.

Parameters:
ADDR_W, 16, sample ROM address width
RATE_DIV, 1088, I_CLK_12M cycles per output sample (12 MHz / 1088 ≈ 11.03 kHz); legal range 4..65535

Ports:
I_CLK_12M  in  1  system clock, 12 MHz
I_RESET  in  1  reset, asynchronous, active-high
I_TRIG  in  1  single-cycle start pulse
I_START_ADDR  in  ADDR_W  first sample address, latched on I_TRIG
I_END_ADDR  in  ADDR_W  last sample address (inclusive), latched on I_TRIG
I_LOOP  in  1  loop enable, latched on I_TRIG
O_ROM_ADDR  out  ADDR_W  ROM fetch address
O_ROM_REQ  out  1  ROM fetch request
I_ROM_ACK  in  1  one-cycle acknowledge; I_ROM_DATA valid in the same cycle
I_ROM_DATA  in  8  unsigned PCM, 0x80 = silence
O_SND  out  16  signed sample to the mixer
O_BUSY  out  1  high while not IDLE

Behaviour:
- Reset state:
  - State = IDLE.
  - O_SND = 0, O_ROM_REQ = 0, O_ROM_ADDR = 0, O_BUSY = 0.
  - Rate counter = 0; pending-valid flag = 0; retrigger flag = 0.
- States: IDLE, FETCH, WAIT, DRAIN.
- IDLE + I_TRIG:
  - Latch start, end and loop; addr = start; rate counter = 0; go to FETCH.
- FETCH:
  - O_ROM_REQ = 1 and O_ROM_ADDR = addr, both registered and held stable until I_ROM_ACK.
  - On ack: pending = I_ROM_DATA, pending-valid = 1, O_ROM_REQ drops next cycle, go to WAIT.
- Rate counter:
  - Counts 0..RATE_DIV-1 in every non-IDLE state; the tick fires when the count is RATE_DIV-1, then the count wraps to 0.
  - The first tick occurs exactly RATE_DIV cycles after the trigger cycle.
- Tick with pending-valid:
  - O_SND <= {pending ^ 8'h80, 8'h00}, i.e. (data - 128) << 8, registered. Example: 0xFF -> 0x7F00, 0x00 -> 0x8000, 0x80 -> 0x0000.
  - Clear pending-valid.
  - If addr != end: addr = addr + 1 (mod 2^ADDR_W), go to FETCH.
  - If addr == end and loop: addr = start, go to FETCH.
  - If addr == end and not loop: go to DRAIN.
- Tick without pending-valid (underrun):
  - O_SND holds its previous value and addr does not advance.
  - The outstanding FETCH continues; the sample is emitted on a later tick.
- Address wrap: if start > end, addr wraps through 2^ADDR_W-1 to 0 and playback continues up to end.
- start == end: one sample is played.
- DRAIN:
  - O_SND holds the last sample until the next tick.
  - On that tick O_SND = 0, state = IDLE, O_BUSY = 0.
- Retrigger (I_TRIG while not IDLE):
  - If O_ROM_REQ = 0: restart immediately, exactly as from IDLE, and discard any pending sample.
  - If O_ROM_REQ = 1: set the retrigger flag and relatch addr/end/loop from the new inputs. The current request completes, its data is discarded, then the block restarts at the new start address with the rate counter at 0.
  - O_SND holds its value across a restart.
- I_TRIG in the same cycle as an internal tick: the trigger wins and the tick's output update is suppressed.
- I_ROM_ACK when O_ROM_REQ = 0: ignored.
- Reset asserted mid-playback: all outputs return to reset values immediately (asynchronous), including O_ROM_REQ, even with an ack outstanding.

Optional Feature:
- Macro: SAMPLE_VOLUME_EN.
- When defined:
  - Adds input I_VOL [3:0], sampled on every tick.
  - O_SND = ((data - 128) << 8) * (I_VOL + 1), arithmetically shifted right by 4 in a 21-bit signed intermediate and truncated to 16 bits. The result cannot overflow.
  - I_VOL = 15 gives the same output as the build without the feature; I_VOL = 0 gives 1/16 scale.
  - Adds one register stage, so O_SND updates one cycle after the tick.
- When not defined: I_VOL is absent and the output is the unscaled conversion, updated on the tick.

Test Plan:
- RATE_DIV = 8; ROM acks 2 cycles after req; start = 0x0010, end = 0x0012, loop = 0; data 0xFF, 0x00, 0x80 -> O_SND = 0x7F00, 0x8000, 0x0000 on cycles 8, 16, 24 after the trigger; O_SND = 0 and O_BUSY = 0 at cycle 32.
- Same setup with loop = 1 -> ROM addresses requested are 0x10, 0x11, 0x12, 0x10, 0x11; O_BUSY stays high.
- ROM ack latency 12 cycles with RATE_DIV = 8 -> the first tick leaves O_SND at 0 and the sample appears on the tick at cycle 16; no address is skipped.
- start = 0xFFFF, end = 0x0001 -> ROM addresses requested are 0xFFFF, 0x0000, 0x0001, then DRAIN.
- Retrigger while a request is outstanding -> O_ROM_REQ is held until the ack, that data never appears on O_SND, the next request is to the new start address, and the first new sample appears RATE_DIV cycles after the restart.
- Reset pulse mid-FETCH -> O_ROM_REQ, O_SND and O_BUSY are 0 within the reset cycle, and a later ack is ignored. With SAMPLE_VOLUME_EN and I_VOL = 7, data 0xFF -> O_SND = 0x3F80.

Source files
------------

// File: rtl/mario_sample_player.sv
// Single-channel PCM playback: fetches 8-bit unsigned samples from ROM on a trigger and paces them out as signed 16-bit.
// Build option SAMPLE_VOLUME_EN adds a 4-bit volume input and one extra output register stage.
`timescale 1ns/1ps
module mario_sample_player #(
    parameter int ADDR_W   = 16,
    parameter int RATE_DIV = 1088
) (
    input  logic              I_CLK_12M,
    input  logic              I_RESET,
    input  logic              I_TRIG,
    input  logic [ADDR_W-1:0] I_START_ADDR,
    input  logic [ADDR_W-1:0] I_END_ADDR,
    input  logic              I_LOOP,
    output logic [ADDR_W-1:0] O_ROM_ADDR,
    output logic              O_ROM_REQ,
    input  logic              I_ROM_ACK,
    input  logic [7:0]        I_ROM_DATA,
`ifdef SAMPLE_VOLUME_EN
    input  logic [3:0]        I_VOL,
`endif
    output logic [15:0]       O_SND,
    output logic              O_BUSY
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_t;
    localparam logic [15:0] RATE_LAST = 16'(RATE_DIV - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] start_reg, end_reg, addr_reg, rom_addr_reg;
    logic              loop_reg, rom_req_reg, pending_valid_reg, retrig_reg;
    logic [7:0]        pending_reg;
    logic [15:0]       rate_cnt_reg, snd_reg;

    logic              tick, rom_ack;
    logic [ADDR_W-1:0] addr_inc;
    logic              out_load;
    logic [15:0]       out_value;

    assign tick     = (state_reg != S_IDLE) && (rate_cnt_reg == RATE_LAST);
    assign rom_ack  = I_ROM_ACK && rom_req_reg;
    assign addr_inc = addr_reg + ADDR_W'(1);

    // A trigger in the tick cycle suppresses the output update.
    always_comb begin
        out_load  = 1'b0;
        out_value = '0;
        if (tick && !I_TRIG) begin
            if (state_reg == S_WAIT && pending_valid_reg) begin
                out_load  = 1'b1;
                out_value = {pending_reg ^ 8'h80, 8'h00};
            end else if (state_reg == S_DRAIN) begin
                out_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
        if (I_RESET) begin
            state_reg         <= S_IDLE;
            start_reg         <= '0;
            end_reg           <= '0;
            addr_reg          <= '0;
            loop_reg          <= 1'b0;
            rom_addr_reg      <= '0;
            rom_req_reg       <= 1'b0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            retrig_reg        <= 1'b0;
            rate_cnt_reg      <= '0;
        end else if (I_TRIG) begin
            start_reg         <= I_START_ADDR;
            end_reg           <= I_END_ADDR;
            loop_reg          <= I_LOOP;
            addr_reg          <= I_START_ADDR;
            rate_cnt_reg      <= '0;
            pending_valid_reg <= 1'b0;
            state_reg         <= S_FETCH;
            if (!rom_req_reg) begin
                rom_req_reg  <= 1'b1;
                rom_addr_reg <= I_START_ADDR;
                retrig_reg   <= 1'b0;
            end else if (I_ROM_ACK) begin
                // Outstanding fetch completes this cycle; drop it and reissue next cycle.
                rom_req_reg <= 1'b0;
                retrig_reg  <= 1'b0;
            end else begin
                retrig_reg <= 1'b1;
            end
        end else if (state_reg != S_IDLE) begin
            rate_cnt_reg <= tick ? '0 : rate_cnt_reg + 16'd1;
            case (state_reg)
                S_FETCH: begin
                    if (rom_ack) begin
                        rom_req_reg <= 1'b0;
                        if (retrig_reg) begin
                            retrig_reg   <= 1'b0;
                            rate_cnt_reg <= '0;
                        end else begin
                            pending_reg       <= I_ROM_DATA;
                            pending_valid_reg <= 1'b1;
                            state_reg         <= S_WAIT;
                        end
                    end else if (!rom_req_reg) begin
                        rom_req_reg  <= 1'b1;
                        rom_addr_reg <= addr_reg;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        pending_valid_reg <= 1'b0;
                        state_reg         <= S_FETCH;
                        if (addr_reg != end_reg) begin
                            addr_reg     <= addr_inc;
                            rom_addr_reg <= addr_inc;
                            rom_req_reg  <= 1'b1;
                        end else if (loop_reg) begin
                            addr_reg     <= start_reg;
                            rom_addr_reg <= start_reg;
                            rom_req_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tick) state_reg <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

`ifdef SAMPLE_VOLUME_EN
    logic               stage_vld_reg;
    logic signed [15:0] stage_val_reg;
    logic [3:0]         vol_reg;
    logic signed [20:0] samp_ext, gain_ext, scaled;

    assign samp_ext = 21'(stage_val_reg);
    assign gain_ext = 21'({1'b0, vol_reg} + 5'd1);
    assign scaled   = samp_ext * gain_ext;

    always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
        if (I_RESET) begin
            stage_vld_reg <= 1'b0;
            stage_val_reg <= '0;
            vol_reg       <= '0;
            snd_reg       <= '0;
        end else begin
            stage_vld_reg <= out_load;
            if (out_load) begin
                stage_val_reg <= out_value;
                vol_reg       <= I_VOL;
            end
            if (stage_vld_reg) snd_reg <= 16'(scaled >>> 4);
        end
    end
`else
    always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
        if (I_RESET)       snd_reg <= '0;
        else if (out_load) snd_reg <= out_value;
    end
`endif

    assign O_ROM_ADDR = rom_addr_reg;
    assign O_ROM_REQ  = rom_req_reg;
    assign O_SND      = snd_reg;
    assign O_BUSY     = (state_reg != S_IDLE);
endmodule

// File: tb/tb_mario_sample_player.sv
// Scoreboard bench for mario_sample_player with RATE_DIV = 8 and a latency-programmable ROM responder.
`timescale 1ns/1ps
module tb_mario_sample_player;
    localparam int RATE = 8;
`ifdef SAMPLE_VOLUME_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif
    localparam int SEL_SND = 0, SEL_BUSY = 1, SEL_REQ = 2;

    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] addr_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] start_addr = '0, end_addr = '0;
    logic        loop_en = 1'b0;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic [15:0] snd;
    logic        busy;
`ifdef SAMPLE_VOLUME_EN
    logic [3:0]  vol = 4'd15;
`endif

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          rom_lat = 2;
    int          req_cnt = 0;
    logic        model_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [7:0]  model_data = '0;

    assign rom_ack  = model_ack | spur_ack;
    assign rom_data = model_ack ? model_data : 8'hFF;

    mario_sample_player #(.ADDR_W(16), .RATE_DIV(RATE)) dut (
        .I_CLK_12M    (clk),
        .I_RESET      (rst),
        .I_TRIG       (trig),
        .I_START_ADDR (start_addr),
        .I_END_ADDR   (end_addr),
        .I_LOOP       (loop_en),
        .O_ROM_ADDR   (rom_addr),
        .O_ROM_REQ    (rom_req),
        .I_ROM_ACK    (rom_ack),
        .I_ROM_DATA   (rom_data),
`ifdef SAMPLE_VOLUME_EN
        .I_VOL        (vol),
`endif
        .O_SND        (snd),
        .O_BUSY       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        case (a)
            16'h0010: return 8'hFF;
            16'h0011: return 8'h00;
            16'h0012: return 8'h80;
            16'hFFFF: return 8'h40;
            16'h0000: return 8'hC0;
            16'h0001: return 8'h81;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // ROM responder: ack rom_lat cycles after the request rises; checks requested addresses.
    always @(negedge clk) begin
        if (model_ack || !rom_req) begin
            model_ack = 1'b0;
            req_cnt   = 0;
        end else begin
            req_cnt++;
            if (req_cnt == rom_lat) begin
                model_ack  = 1'b1;
                model_data = rom_byte(rom_addr);
                if (addr_q.size() > 0) check_value("rom_addr", rom_addr, addr_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] got;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_SND:  got = snd;
                SEL_BUSY: got = {15'd0, busy};
                default:  got = {15'd0, rom_req};
            endcase
            check_value(e.tag, got, e.exp);
        end
    end

    task automatic push_exp(input int due, input int sel, input logic [15:0] v, input string tag);
        exp_t e;
        int   i;
        e.due = due; e.sel = sel; e.exp = v; e.tag = tag;
        i = 0;
        while (i < sb_q.size() && sb_q[i].due <= due) i++;
        sb_q.insert(i, e);
        $display("[TB] expect %s = %h at cycle %0d", tag, v, due);
    endtask

    // Called at a falling edge; returns the cycle number of the edge that sampled the trigger.
    task automatic do_trig(input logic [15:0] s, input logic [15:0] e, input logic lp, output int t);
        start_addr = s; end_addr = e; loop_en = lp; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        t = cyc;
        $display("[TB] trigger start=%h end=%h loop=%0d at cycle %0d", s, e, lp, t);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && (sb_q.size() > 0 || addr_q.size() > 0); i++) @(negedge clk);
        if (sb_q.size() > 0 || addr_q.size() > 0) begin
            check_value("timeout", sb_q.size() + addr_q.size(), 0);
            sb_q.delete();
            addr_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int t, t1;
        repeat (3) @(negedge clk);
        check_value("rst_snd", snd, 0);
        check_value("rst_req", rom_req, 0);
        check_value("rst_addr", rom_addr, 0);
        check_value("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // One-shot 0x10..0x12
        rom_lat = 2;
        do_trig(16'h0010, 16'h0012, 1'b0, t);
        addr_q.push_back(16'h0010); addr_q.push_back(16'h0011); addr_q.push_back(16'h0012);
        push_exp(t + 7 + L,  SEL_SND,  16'h0000, "b_pre");
        push_exp(t + 8 + L,  SEL_SND,  16'h7F00, "b_s0");
        push_exp(t + 16 + L, SEL_SND,  16'h8000, "b_s1");
        push_exp(t + 24 + L, SEL_SND,  16'h0000, "b_s2");
        push_exp(t + 31,     SEL_BUSY, 16'h0001, "b_busy");
        push_exp(t + 32,     SEL_BUSY, 16'h0000, "b_idle");
        push_exp(t + 32 + L, SEL_SND,  16'h0000, "b_drain");
        wait_done(100);

        // Looping
        do_trig(16'h0010, 16'h0012, 1'b1, t);
        addr_q.push_back(16'h0010); addr_q.push_back(16'h0011); addr_q.push_back(16'h0012);
        addr_q.push_back(16'h0010); addr_q.push_back(16'h0011);
        push_exp(t + 32 + L, SEL_SND,  16'h7F00, "l_wrap");
        push_exp(t + 40,     SEL_BUSY, 16'h0001, "l_busy");
        wait_done(100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Slow ROM: underrun holds output, no address skipped
        rom_lat = 12;
        do_trig(16'h0010, 16'h0012, 1'b0, t);
        addr_q.push_back(16'h0010); addr_q.push_back(16'h0011); addr_q.push_back(16'h0012);
        push_exp(t + 8 + L,  SEL_SND,  16'h0000, "u_t1");
        push_exp(t + 16 + L, SEL_SND,  16'h7F00, "u_t2");
        push_exp(t + 24 + L, SEL_SND,  16'h7F00, "u_hold1");
        push_exp(t + 32 + L, SEL_SND,  16'h8000, "u_t4");
        push_exp(t + 40 + L, SEL_SND,  16'h8000, "u_hold2");
        push_exp(t + 48 + L, SEL_SND,  16'h0000, "u_t6");
        push_exp(t + 55,     SEL_BUSY, 16'h0001, "u_busy");
        push_exp(t + 56,     SEL_BUSY, 16'h0000, "u_idle");
        wait_done(150);

        // Address wrap through 0xFFFF
        rom_lat = 2;
        do_trig(16'hFFFF, 16'h0001, 1'b0, t);
        addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000); addr_q.push_back(16'h0001);
        push_exp(t + 8 + L,  SEL_SND,  16'hC000, "w_s0");
        push_exp(t + 16 + L, SEL_SND,  16'h4000, "w_s1");
        push_exp(t + 24 + L, SEL_SND,  16'h0100, "w_s2");
        push_exp(t + 31,     SEL_BUSY, 16'h0001, "w_busy");
        push_exp(t + 32,     SEL_BUSY, 16'h0000, "w_idle");
        push_exp(t + 32 + L, SEL_SND,  16'h0000, "w_drain");
        wait_done(100);

        // Retrigger with a fetch outstanding; new run is a single sample
        rom_lat = 6;
        do_trig(16'h0020, 16'h0022, 1'b0, t);
        addr_q.push_back(16'h0020); addr_q.push_back(16'h0030);
        @(negedge clk);
        do_trig(16'h0030, 16'h0030, 1'b0, t1);
        push_exp(t + 5,      SEL_REQ,  16'h0001, "r_hold");
        push_exp(t + 8 + L,  SEL_SND,  16'h0000, "r_nodata");
        push_exp(t + 13 + L, SEL_SND,  16'h0000, "r_pre");
        push_exp(t + 14 + L, SEL_SND,  16'hEA00, "r_new");
        push_exp(t + 21,     SEL_BUSY, 16'h0001, "r_busy");
        push_exp(t + 22,     SEL_BUSY, 16'h0000, "r_idle");
        push_exp(t + 22 + L, SEL_SND,  16'h0000, "r_drain");
        wait_done(100);

        // Asynchronous reset mid-fetch, then a stray ack
        rom_lat = 4;
        do_trig(16'h0010, 16'h0012, 1'b0, t);
        repeat (9) @(negedge clk);
        #2;
        check_value("x_req_pre", rom_req, 1);
        check_value("x_snd_pre", snd, 16'h7F00);
        rst = 1'b1;
        #1;
        check_value("x_req", rom_req, 0);
        check_value("x_snd", snd, 0);
        check_value("x_busy", busy, 0);
        check_value("x_addr", rom_addr, 0);
        $display("[TB] reset asserted mid-fetch at cycle %0d", cyc);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_value("x_ack_req", rom_req, 0);
        check_value("x_ack_busy", busy, 0);
        check_value("x_ack_snd", snd, 0);

`ifdef SAMPLE_VOLUME_EN
        vol = 4'd7;
        rom_lat = 2;
        do_trig(16'h0010, 16'h0010, 1'b0, t);
        addr_q.push_back(16'h0010);
        push_exp(t + 9,  SEL_SND,  16'h3F80, "v_half");
        push_exp(t + 16, SEL_BUSY, 16'h0000, "v_idle");
        push_exp(t + 17, SEL_SND,  16'h0000, "v_drain");
        wait_done(100);
        vol = 4'd15;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
